// File: rtl/dbg_loader.sv
// Byte-stream debug loader: host commands set an address, burst-write or burst-read
// a debug memory port, or ping. One command byte in, zero or more response bytes out.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | waiting for a command byte
// ADDR_HI   | waiting for address high byte
// ADDR_LO   | waiting for address low byte
// WCNT      | waiting for write byte count
// WDATA     | waiting for next write data byte
// WSETUP    | write address/data presented, strobe low
// WSTROBE   | write strobe high
// RCNT      | waiting for read byte count
// RSETUP    | read address presented, strobe low
// RSTROBE   | read strobe high
// RCAPTURE  | strobe low, read data sampled into tx_data
// TXWAIT    | read byte offered on tx, waiting for host
// TXRESP    | single response byte (ack/ping/error) on tx
module dbg_loader #(
  parameter logic [7:0] PING_RESP = 8'hA5,
  parameter logic [7:0] ERR_RESP  = 8'hEE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        dbg_mem_op,
  output logic        dbg_mem_clk,
  output logic [15:0] dbg_addr,
  output logic [7:0]  dbg_data_out,
  input  logic [7:0]  dbg_data_in,
  output logic        dbg_RW,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_WCNT, S_WDATA, S_WSETUP, S_WSTROBE,
    S_RCNT, S_RSETUP, S_RSTROBE, S_RCAPTURE, S_TXWAIT, S_TXRESP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  data_out_q, data_out_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        rx_ready_q, rx_ready_d;
  logic        busy_q, busy_d;
  logic        mem_op_q, mem_op_d;
  logic        mem_clk_q, mem_clk_d;
  logic        rw_q, rw_d;
  logic        rx_fire, tx_fire;

  assign rx_fire = rx_valid & rx_ready_q;
  assign tx_fire = tx_valid_q & tx_ready;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    case (state_q)
      S_IDLE: if (rx_fire) begin
        case (rx_data)
          8'h01:   state_d = S_ADDR_HI;
          8'h02:   state_d = S_WCNT;
          8'h03:   state_d = S_RCNT;
          8'h04: begin
            tx_data_d  = PING_RESP;
            tx_valid_d = 1'b1;
            state_d    = S_TXRESP;
          end
          default: begin
            tx_data_d  = ERR_RESP;
            tx_valid_d = 1'b1;
            state_d    = S_TXRESP;
          end
        endcase
      end
      S_ADDR_HI: if (rx_fire) begin
        addr_d[15:8] = rx_data;
        state_d      = S_ADDR_LO;
      end
      S_ADDR_LO: if (rx_fire) begin
        addr_d[7:0] = rx_data;
        state_d     = S_IDLE;
      end
      S_WCNT: if (rx_fire) begin
        cnt_d   = rx_data;
        state_d = S_WDATA;
      end
      S_WDATA: if (rx_fire) begin
        data_out_d = rx_data;
        state_d    = S_WSETUP;
      end
      S_WSETUP: state_d = S_WSTROBE;
      S_WSTROBE: begin
        addr_d = addr_q + 16'd1;
        cnt_d  = cnt_q - 8'd1;
        // count loaded as 0 wraps to 255 here, giving 256 bytes in total
        if (cnt_q == 8'd1) begin
          tx_data_d  = 8'h00;
          tx_valid_d = 1'b1;
          state_d    = S_TXRESP;
        end else begin
          state_d = S_WDATA;
        end
      end
      S_RCNT: if (rx_fire) begin
        cnt_d   = rx_data;
        state_d = S_RSETUP;
      end
      S_RSETUP:  state_d = S_RSTROBE;
      S_RSTROBE: state_d = S_RCAPTURE;
      S_RCAPTURE: begin
        tx_data_d  = dbg_data_in;
        tx_valid_d = 1'b1;
        state_d    = S_TXWAIT;
      end
      S_TXWAIT: if (tx_fire) begin
        tx_valid_d = 1'b0;
        addr_d     = addr_q + 16'd1;
        cnt_d      = cnt_q - 8'd1;
        state_d    = (cnt_q == 8'd1) ? S_IDLE : S_RSETUP;
      end
      S_TXRESP: if (tx_fire) begin
        tx_valid_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Strobe/handshake outputs follow the next state so they line up with it when registered
    rx_ready_d = state_d inside {S_IDLE, S_ADDR_HI, S_ADDR_LO, S_WCNT, S_WDATA, S_RCNT};
    busy_d     = (state_d != S_IDLE);
    mem_op_d   = state_d inside {S_WSETUP, S_WSTROBE, S_RSETUP, S_RSTROBE, S_RCAPTURE};
    mem_clk_d  = state_d inside {S_WSTROBE, S_RSTROBE};
    rw_d       = !(state_d inside {S_WSETUP, S_WSTROBE});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= 16'h0000;
      cnt_q      <= 8'h00;
      data_out_q <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      mem_op_q   <= 1'b0;
      mem_clk_q  <= 1'b0;
      rw_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rx_ready_q <= rx_ready_d;
      busy_q     <= busy_d;
      mem_op_q   <= mem_op_d;
      mem_clk_q  <= mem_clk_d;
      rw_q       <= rw_d;
    end
  end

  assign rx_ready     = rx_ready_q;
  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign dbg_mem_op   = mem_op_q;
  assign dbg_mem_clk  = mem_clk_q;
  assign dbg_addr     = addr_q;
  assign dbg_data_out = data_out_q;
  assign dbg_RW       = rw_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_dbg_loader.sv
// Directed bench for dbg_loader: byte-level host driver, behavioural debug memory
// and strobe logger, expected values written out by hand per step.
module tb_dbg_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        dbg_mem_op;
  logic        dbg_mem_clk;
  logic [15:0] dbg_addr;
  logic [7:0]  dbg_data_out;
  logic [7:0]  dbg_data_in;
  logic        dbg_RW;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  int          n_wr = 0;
  int          n_rd = 0;
  int          rw0_cnt = 0;
  int          txv_cnt = 0;

  dbg_loader dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .dbg_mem_op(dbg_mem_op), .dbg_mem_clk(dbg_mem_clk), .dbg_addr(dbg_addr),
    .dbg_data_out(dbg_data_out), .dbg_data_in(dbg_data_in), .dbg_RW(dbg_RW),
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign dbg_data_in = mem[dbg_addr];

  always @(posedge dbg_mem_clk) begin
    if (dbg_mem_op && !dbg_RW) begin
      mem[dbg_addr] = dbg_data_out;
      wr_addr_q.push_back(dbg_addr);
      wr_data_q.push_back(dbg_data_out);
      n_wr++;
    end else if (dbg_mem_op) begin
      n_rd++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && !dbg_RW) rw0_cnt++;
    if (tx_valid) txv_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was consumed.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rx_accept", {31'd0, rx_ready}, 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic recv_byte(input string tag, input int stall, input logic [7:0] exp);
    int n = 0;
    while (!tx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, {31'd0, tx_valid}, 32'd1);
    chk({tag, "_data"}, {24'd0, tx_data}, {24'd0, exp});
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, {31'd0, tx_valid}, 32'd1);
      chk({tag, "_hold_data"}, {24'd0, tx_data}, {24'd0, exp});
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    chk({tag, "_drop"}, {31'd0, tx_valid}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
    chk({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    chk({tag, "_addr"}, {16'd0, dbg_addr}, 32'd0);
    chk({tag, "_mem_op"}, {31'd0, dbg_mem_op}, 32'd0);
    chk({tag, "_mem_clk"}, {31'd0, dbg_mem_clk}, 32'd0);
    chk({tag, "_rw"}, {31'd0, dbg_RW}, 32'd1);
    chk({tag, "_data_out"}, {24'd0, dbg_data_out}, 32'd0);
  endtask

  initial begin
    int base;
    int snap_wr;
    int snap_rd;
    int snap_rw0;
    int snap_txv;
    rst_n = 1'b0;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;
    #1 chk("por_rx_ready_pre", {31'd0, rx_ready}, 32'd0);
    @(negedge clk);
    chk("por_rx_ready_post", {31'd0, rx_ready}, 32'd1);
    chk("por_busy_post", {31'd0, busy}, 32'd0);

    // mid-cycle async reset while busy with a nonzero address
    send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    chk("addr_load", {16'd0, dbg_addr}, 32'h1234);
    send_byte(8'h02); send_byte(8'h01); send_byte(8'h5C);
    chk("busy_mid", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_rx_ready_pre", {31'd0, rx_ready}, 32'd0);
    @(negedge clk);
    chk("rel_rx_ready_post", {31'd0, rx_ready}, 32'd1);

    // three-byte write
    base = wr_addr_q.size();
    snap_wr = n_wr;
    foreach (wr_addr_q[i]) ;
    send_byte(8'h01); send_byte(8'h80); send_byte(8'h00);
    send_byte(8'h02); send_byte(8'h03);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    recv_byte("wr_ack", 0, 8'h00);
    chk("wr_count", n_wr - snap_wr, 32'd3);
    chk("wr0_addr", {16'd0, wr_addr_q[base]}, 32'h8000);
    chk("wr0_data", {24'd0, wr_data_q[base]}, 32'hAA);
    chk("wr1_addr", {16'd0, wr_addr_q[base+1]}, 32'h8001);
    chk("wr1_data", {24'd0, wr_data_q[base+1]}, 32'hBB);
    chk("wr2_addr", {16'd0, wr_addr_q[base+2]}, 32'h8002);
    chk("wr2_data", {24'd0, wr_data_q[base+2]}, 32'hCC);
    chk("wr_final_addr", {16'd0, dbg_addr}, 32'h8003);
    chk("wr_idle", {31'd0, busy}, 32'd0);

    // seed 8000=11, 8001=22, then read back with tx stalls
    send_byte(8'h01); send_byte(8'h80); send_byte(8'h00);
    send_byte(8'h02); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
    recv_byte("seed_ack", 0, 8'h00);
    snap_rw0 = rw0_cnt;
    snap_wr = n_wr;
    snap_rd = n_rd;
    send_byte(8'h01); send_byte(8'h80); send_byte(8'h00);
    send_byte(8'h03); send_byte(8'h02);
    chk("rd_no_rx", {31'd0, rx_ready}, 32'd0);
    recv_byte("rd0", 5, 8'h11);
    recv_byte("rd1", 5, 8'h22);
    chk("rd_rw_never0", rw0_cnt - snap_rw0, 32'd0);
    chk("rd_no_write", n_wr - snap_wr, 32'd0);
    chk("rd_strobes", n_rd - snap_rd, 32'd2);
    chk("rd_final_addr", {16'd0, dbg_addr}, 32'h8002);
    chk("rd_idle_rx", {31'd0, rx_ready}, 32'd1);

    // address wrap
    base = wr_addr_q.size();
    send_byte(8'h01); send_byte(8'hFF); send_byte(8'hFF);
    send_byte(8'h02); send_byte(8'h02); send_byte(8'h5A); send_byte(8'hA5);
    recv_byte("wrap_ack", 0, 8'h00);
    chk("wrap0_addr", {16'd0, wr_addr_q[base]}, 32'hFFFF);
    chk("wrap0_data", {24'd0, wr_data_q[base]}, 32'h5A);
    chk("wrap1_addr", {16'd0, wr_addr_q[base+1]}, 32'h0000);
    chk("wrap1_data", {24'd0, wr_data_q[base+1]}, 32'hA5);
    chk("wrap_final_addr", {16'd0, dbg_addr}, 32'h0001);

    // ping and unknown command
    send_byte(8'h04);
    recv_byte("ping", 2, 8'hA5);
    send_byte(8'h7F);
    recv_byte("unknown", 1, 8'hEE);
    chk("misc_addr_kept", {16'd0, dbg_addr}, 32'h0001);

    // count byte 0 means 256 writes
    base = wr_addr_q.size();
    snap_wr = n_wr;
    send_byte(8'h02); send_byte(8'h00);
    for (int i = 0; i < 256; i++) send_byte(i[7:0]);
    recv_byte("w256_ack", 0, 8'h00);
    chk("w256_count", n_wr - snap_wr, 32'd256);
    chk("w256_first_addr", {16'd0, wr_addr_q[base]}, 32'h0001);
    chk("w256_last_addr", {16'd0, wr_addr_q[base+255]}, 32'h0100);
    chk("w256_last_data", {24'd0, wr_data_q[base+255]}, 32'hFF);
    chk("w256_final_addr", {16'd0, dbg_addr}, 32'h0101);

    // reset in the middle of a write strobe
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h77);
    @(posedge clk);
    #2 chk("abort_strobe_hi", {31'd0, dbg_mem_clk}, 32'd1);
    snap_wr = n_wr;
    snap_txv = txv_cnt;
    rst_n = 1'b0;
    #1 chk("abort_mem_op", {31'd0, dbg_mem_op}, 32'd0);
    chk("abort_mem_clk", {31'd0, dbg_mem_clk}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_strobe", n_wr - snap_wr, 32'd0);
    chk("abort_no_ack", txv_cnt - snap_txv, 32'd0);
    send_byte(8'h04);
    recv_byte("abort_ping", 0, 8'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/dbg_loader.md
DBG_LOADER -- requirements
Module: dbg_loader

Interface
REQ-001 SHALL have parameter PING_RESP, default 8'hA5: byte returned for PING command.
REQ-002 SHALL have parameter ERR_RESP, default 8'hEE: byte returned for unknown command.
REQ-003 SHALL have ports, in order:
  clk  in  1  single clock; all state on rising edge.
  rst_n  in  1  reset, asynchronous, active-low.
  rx_data  in  8  host command/data byte.
  rx_valid  in  1  rx_data valid.
  rx_ready  out  1  loader accepts rx_data; transfer when rx_valid & rx_ready.
  tx_data  out  8  response byte to host.
  tx_valid  out  1  tx_data valid.
  tx_ready  in  1  host accepts tx_data; transfer when tx_valid & tx_ready.
  dbg_mem_op  out  1  debug memory operation select.
  dbg_mem_clk  out  1  debug memory clock strobe.
  dbg_addr  out  16  debug memory address.
  dbg_data_out  out  8  write data to memory.
  dbg_data_in  in  8  read data from memory.
  dbg_RW  out  1  1 = read, 0 = write.
  busy  out  1  high whenever state != IDLE.

Function
REQ-004 SHALL decode command bytes in IDLE: 8'h01 ADDR, 8'h02 WRITE, 8'h03 READ, 8'h04 PING; any other value is unknown.
REQ-005 SHALL assert rx_ready only in IDLE, ADDR_HI, ADDR_LO, WCNT, WDATA, RCNT; deasserted in all other states.
REQ-006 ADDR: next two accepted bytes load dbg_addr[15:8] then dbg_addr[7:0]; returns to IDLE; no response byte.
REQ-007 WRITE: next byte is count N (8'h00 means 256); then N data bytes, each written to dbg_addr, dbg_addr incremented after each write.
REQ-008 Write access per byte: WSETUP (dbg_mem_op=1, dbg_RW=0, dbg_data_out=byte, dbg_mem_clk=0) one cycle, then WSTROBE (same, dbg_mem_clk=1) one cycle, then dbg_addr+1 and back to WDATA or done.
REQ-009 After the Nth write, loader SHALL send one ack byte 8'h00 on tx, then return to IDLE.
REQ-010 READ: next byte is count N (8'h00 means 256); loader performs N reads starting at dbg_addr, no further rx bytes consumed.
REQ-011 Read access per byte: RSETUP (dbg_mem_op=1, dbg_RW=1, dbg_mem_clk=0) one cycle, RSTROBE (dbg_mem_clk=1) one cycle, RCAPTURE (dbg_mem_clk=0) samples dbg_data_in into tx_data, then TXWAIT until tx handshake; dbg_addr+1 after handshake.
REQ-012 Outside WSETUP/WSTROBE/RSETUP/RSTROBE/RCAPTURE, dbg_mem_op=0, dbg_mem_clk=0, dbg_RW=1.
REQ-013 dbg_RW SHALL be 0 only in WSETUP/WSTROBE; no write strobe ever occurs in a read sequence.
REQ-014 PING: send PING_RESP; unknown: send ERR_RESP; both return to IDLE after tx handshake.
REQ-015 tx_valid, once high, SHALL stay high with tx_data stable until tx_ready sampled high; deasserts the cycle after the handshake.
REQ-016 Remaining count: 8-bit, loaded with N, decremented per completed byte; sequence ends when decrement goes 1->0 (load of 0 gives 256 bytes).
REQ-017 dbg_addr SHALL wrap 16'hFFFF -> 16'h0000 without error; dbg_addr persists across commands.
REQ-018 rx bytes are never dropped: a byte is consumed only on a valid&ready cycle; rx_valid while rx_ready=0 is held by the host.
REQ-019 Minimum per-write cost 3 cycles (WDATA accept, WSETUP, WSTROBE); minimum per-read cost 4 cycles plus tx stall.

Reset
REQ-020 On rst_n low, immediately and asynchronously: state IDLE, dbg_addr=16'h0000, count=0, dbg_mem_op=0, dbg_mem_clk=0, dbg_RW=1, dbg_data_out=0, tx_data=0, tx_valid=0, rx_ready=0, busy=0.
REQ-021 rx_ready SHALL rise the first clock after rst_n deasserts; reset mid-access aborts it with no further strobe.

Verification
REQ-022 Reset: rst_n low mid-cycle -> all outputs at REQ-020 values before next clk edge; first clk after release -> rx_ready=1.
REQ-023 Write: 01 80 00 02 03 AA BB CC -> three dbg_mem_clk pulses with dbg_RW=0 at 8000/AA, 8001/BB, 8002/CC; tx 8'h00; dbg_addr=8003.
REQ-024 Read with stall: memory 8000=11, 8001=22; 01 80 00 03 02, tx_ready low 5 cycles each -> tx 11 then 22, tx_data stable while stalled, dbg_RW never 0.
REQ-025 Wrap: 01 FF FF 02 02 5A A5 -> writes at FFFF then 0000; final dbg_addr=0001.
REQ-026 Misc: 04 -> tx A5; 7F -> tx EE; 02 00 + 256 bytes -> exactly 256 write strobes then tx 00.
REQ-027 Reset during WSTROBE of 02 03 sequence -> dbg_mem_op/dbg_mem_clk drop immediately, no tx ack, next command 04 -> tx A5.
